// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counter timer: FSM states,
// register offsets, CTRL field positions, mode codes and bridge base addresses.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } timer_state_e;

   // Register select taken from addr[3:2]
   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;
   localparam logic [1:0] OFF_RSVD   = 2'd3;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM_BIT   = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_AUTO    = 2'b01;

   localparam logic [31:0] TIMER0_BASE = 32'h0000_7f00;
   localparam logic [31:0] TIMER1_BASE = 32'h0000_7f10;

   // Modes 10/11 fall back to one-shot, so only the exact auto-reload code counts.
   function automatic logic is_auto_reload(input logic [3:0] ctrl);
      return (ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_AUTO);
   endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counter timer with one-shot and auto-reload modes.
// CTRL/PRESET are writable, COUNT is read-only; IRQ = irq_flag & CTRL.IM.
module timer_counter
   import timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        WE,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        IRQ
);

   timer_state_e state_r, state_s;
   logic [3:0]   ctrl_r, ctrl_s;
   logic [31:0]  preset_r, preset_s;
   logic [31:0]  count_r, count_s;
   logic         irq_flag_r, irq_flag_s;
   logic [1:0]   off_s;
   logic         ctrl_wr_s;
   logic         preset_wr_s;
   logic         unused_addr_s;

   assign off_s         = addr[3:2];
   assign ctrl_wr_s     = WE && (off_s == OFF_CTRL);
   assign preset_wr_s   = WE && (off_s == OFF_PRESET);
   assign unused_addr_s = ^{addr[31:4], addr[1:0]};

   // Next-state, counter and flag logic; a CTRL write overrides the FSM.
   always_comb begin
      state_s    = state_r;
      ctrl_s     = ctrl_r;
      preset_s   = preset_r;
      count_s    = count_r;
      irq_flag_s = irq_flag_r;

      if (preset_wr_s) begin
         preset_s = data_in;
      end else begin
         preset_s = preset_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (ctrl_r[CTRL_EN_BIT]) begin
               state_s = ST_LOAD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            count_s = preset_r;
            state_s = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_r[CTRL_EN_BIT]) begin
               state_s = ST_IDLE;
            end else if (count_r > 32'd1) begin
               count_s = count_r - 32'd1;
            end else begin
               // Count of 0 expires like 1, so PRESET=0 never wraps.
               count_s    = 32'd0;
               irq_flag_s = 1'b1;
               state_s    = ST_INT;
            end
         end
         ST_INT: begin
            if (is_auto_reload(ctrl_r)) begin
               irq_flag_s = 1'b0;
               state_s    = ST_LOAD;
            end else begin
               ctrl_s[CTRL_EN_BIT] = 1'b0;
               state_s             = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      if (ctrl_wr_s) begin
         ctrl_s     = data_in[3:0];
         state_s    = ST_IDLE;
         irq_flag_s = 1'b0;
         count_s    = count_r;
      end else begin
         ctrl_s = ctrl_s;
      end
   end

   // State and register file, synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         ctrl_r     <= 4'd0;
         preset_r   <= 32'd0;
         count_r    <= 32'd0;
         irq_flag_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         ctrl_r     <= ctrl_s;
         preset_r   <= preset_s;
         count_r    <= count_s;
         irq_flag_r <= irq_flag_s;
      end
   end

   // Combinational read mux; the reserved offset reads zero.
   always_comb begin
      data_out = 32'd0;
      case (off_s)
         OFF_CTRL:   data_out = {28'd0, ctrl_r};
         OFF_PRESET: data_out = preset_r;
         OFF_COUNT:  data_out = count_r;
         default:    data_out = 32'd0;
      endcase
   end

   assign IRQ = irq_flag_r & ctrl_r[CTRL_IM_BIT];

endmodule
